// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state, opcode, instruction-class and control encodings for ctrl_fsm
package ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RESET  = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_DECODE = 3'd2;
  localparam state_t ST_EXEC   = 3'd3;
  localparam state_t ST_MEM    = 3'd4;
  localparam state_t ST_WB     = 3'd5;
  localparam state_t ST_TRAP   = 3'd6;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_IMM = 2'b10;
  localparam logic [1:0] RES_PC4 = 2'b11;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] JMP_RST  = 2'b00;
  localparam logic [1:0] JMP_NEXT = 2'b01;
  localparam logic [1:0] JMP_IMM  = 2'b10;
  localparam logic [1:0] JMP_EXC  = 2'b11;

  typedef enum logic [2:0] {
    CL_R, CL_I, CL_LW, CL_SW, CL_BEQ, CL_JAL, CL_LUI, CL_BAD
  } cls_t;

  function automatic cls_t op_class(input logic [6:0] op);
    cls_t c;
    case (op)
      OP_R:    c = CL_R;
      OP_I:    c = CL_I;
      OP_LW:   c = CL_LW;
      OP_SW:   c = CL_SW;
      OP_BEQ:  c = CL_BEQ;
      OP_JAL:  c = CL_JAL;
      OP_LUI:  c = CL_LUI;
      default: c = CL_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational op/f3/f7 to aluControl plus illegal-instruction flag
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_f3,
  input  logic       i_f7,
  output logic [2:0] o_alu_ctrl,
  output logic       o_illegal
);

  cls_t w_cls;

  assign w_cls = op_class(i_op);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_illegal  = 1'b0;
    case (w_cls)
      CL_R, CL_I: begin
        case (i_f3)
          3'b000:  o_alu_ctrl = (w_cls == CL_R && i_f7) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_ctrl = ALU_SLT;
          3'b110:  o_alu_ctrl = ALU_OR;
          3'b111:  o_alu_ctrl = ALU_AND;
          default: o_illegal  = 1'b1;
        endcase
      end
      CL_LW, CL_SW: o_illegal = (i_f3 != 3'b010);
      CL_BEQ: begin
        o_alu_ctrl = ALU_SUB;
        o_illegal  = (i_f3 != 3'b000);
      end
      CL_JAL, CL_LUI: o_illegal = 1'b0;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb/trap)
// Optional handshake watchdog enabled by defining CTRL_FSM_TIMEOUT_EN.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic [2:0]  f3,
  input  logic        f7,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ir_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        regWrite,
  output logic        aluSrc,
  output logic        branch,
  output logic [1:0]  jump,
  output logic [1:0]  resultSrc,
  output logic [1:0]  inmSrc,
  output logic [2:0]  aluControl,
  output logic        trap,
  output logic [31:0] instret
);

  state_t      r_state;
  state_t      w_next;
  cls_t        r_cls;
  logic [2:0]  r_alu;
  logic [31:0] r_instret;
  logic [2:0]  w_alu;
  logic        w_illegal;
  logic        w_retire;
  logic        w_timeout;

  alu_decoder u_alu_decoder (
    .i_op       (op),
    .i_f3       (f3),
    .i_f7       (f7),
    .o_alu_ctrl (w_alu),
    .o_illegal  (w_illegal)
  );

`ifdef CTRL_FSM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wait_cnt;

  // Cleared on every state change, so each FETCH/MEM visit starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_next != r_state) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_FETCH || r_state == ST_MEM) begin
      r_wait_cnt <= r_wait_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_timeout = &r_wait_cnt;
`else
  logic [TIMEOUT_W-1:0] w_unused_timeout_w;

  assign w_unused_timeout_w = '0;
  assign w_timeout          = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:  w_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready)     w_next = ST_DECODE;
        else if (w_timeout) w_next = ST_TRAP;
      end
      ST_DECODE: w_next = w_illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (r_cls)
          CL_LW, CL_SW:   w_next = ST_MEM;
          CL_BEQ, CL_JAL: w_next = ST_FETCH;
          default:        w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready)     w_next = ST_FETCH;
        else if (w_timeout) w_next = ST_TRAP;
      end
      ST_WB, ST_TRAP: w_next = ST_FETCH;
      default:        w_next = ST_RESET;
    endcase
  end

  assign w_retire = (r_state == ST_WB)
                  || (r_state == ST_MEM && dmem_ready)
                  || (r_state == ST_EXEC && (r_cls == CL_BEQ || r_cls == CL_JAL));

  // The decoded class and ALU op are captured in DECODE so EXEC/MEM/WB stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RESET;
      r_cls     <= CL_BAD;
      r_alu     <= ALU_ADD;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_cls <= op_class(op);
        r_alu <= w_alu;
      end
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign instret = r_instret;

  always_comb begin
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    regWrite   = 1'b0;
    aluSrc     = 1'b0;
    branch     = 1'b0;
    jump       = JMP_RST;
    resultSrc  = RES_ALU;
    inmSrc     = IMM_I;
    aluControl = ALU_ADD;
    trap       = 1'b0;
    case (r_state)
      // rst_n gating keeps every output low while reset is held.
      ST_RESET: pc_en = rst_n;
      ST_FETCH: ir_en = imem_ready;
      ST_EXEC, ST_MEM, ST_WB: begin
        aluControl = r_alu;
        case (r_cls)
          CL_I, CL_LW: aluSrc = 1'b1;
          CL_SW: begin
            aluSrc = 1'b1;
            inmSrc = IMM_S;
          end
          CL_BEQ: begin
            inmSrc = IMM_B;
            branch = zero;
            jump   = JMP_NEXT;
            pc_en  = 1'b1;
          end
          CL_JAL: begin
            inmSrc    = IMM_J;
            resultSrc = RES_PC4;
            regWrite  = 1'b1;
            jump      = JMP_IMM;
            pc_en     = 1'b1;
          end
          CL_LUI:  resultSrc = RES_IMM;
          default: aluSrc = 1'b0;
        endcase
        if (r_state == ST_MEM) begin
          dmem_req = 1'b1;
          dmem_we  = (r_cls == CL_SW);
          jump     = JMP_NEXT;
          pc_en    = dmem_ready;
          if (r_cls == CL_LW && dmem_ready) begin
            regWrite  = 1'b1;
            resultSrc = RES_MEM;
          end
        end
        if (r_state == ST_WB) begin
          regWrite = 1'b1;
          pc_en    = 1'b1;
          jump     = JMP_NEXT;
        end
      end
      ST_TRAP: begin
        pc_en = 1'b1;
        jump  = JMP_EXC;
        trap  = 1'b1;
      end
      default: pc_en = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - directed plus randomized instruction stream checked against a cycle model
module tb_ctrl_fsm;

`ifdef CTRL_FSM_TIMEOUT_EN
  localparam int TW = 3;
`else
  localparam int TW = 8;
`endif

  typedef struct packed {
    logic       pc_en;
    logic       ir_en;
    logic       req;
    logic       we;
    logic       rw;
    logic       asrc;
    logic       br;
    logic [1:0] jump;
    logic [1:0] res;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       trap;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  op = '0;
  logic [2:0]  f3 = '0;
  logic        f7 = 1'b0;
  logic        zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        pc_en, ir_en, dmem_req, dmem_we, regWrite, aluSrc, branch, trap;
  logic [1:0]  jump, resultSrc, inmSrc;
  logic [2:0]  aluControl;
  logic [31:0] instret;

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_instret = '0;

  ctrl_fsm #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .f3(f3), .f7(f7), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ir_en(ir_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .regWrite(regWrite), .aluSrc(aluSrc), .branch(branch), .jump(jump),
    .resultSrc(resultSrc), .inmSrc(inmSrc), .aluControl(aluControl),
    .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic ctl_t obs();
    ctl_t o;
    o.pc_en = pc_en;   o.ir_en = ir_en;   o.req = dmem_req; o.we = dmem_we;
    o.rw    = regWrite; o.asrc = aluSrc;  o.br = branch;    o.jump = jump;
    o.res   = resultSrc; o.imm = inmSrc;  o.alu = aluControl; o.trap = trap;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic chk_ctl(input string tag, input ctl_t e, input ctl_t m);
    chk(tag, 32'(obs() & m), 32'(e & m));
  endtask

  task automatic release_reset();
    ctl_t e;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    e = '0; e.pc_en = 1'b1;
    chk_ctl("reset_pulse", e, '1);
    chk("reset_instret", instret, 32'd0);
    @(posedge clk); #1;
  endtask

  // Walks one instruction from FETCH back to FETCH, checking every cycle.
  task automatic run_instr(input logic [6:0] iop, input logic [2:0] if3, input logic if7,
                           input logic iz, input int fw, input int mw,
                           input int rst_at, input bit to);
    ctl_t e, m;
    logic legal, is_mem, lw;
    logic [2:0] ealu;
    int n;
    legal = 1'b0; ealu = 3'b000;
    case (iop)
      7'h33, 7'h13: begin
        legal = (if3 == 3'd0) || (if3 == 3'd2) || (if3 == 3'd6) || (if3 == 3'd7);
        case (if3)
          3'd0:    ealu = (iop == 7'h33 && if7) ? 3'b001 : 3'b000;
          3'd2:    ealu = 3'b101;
          3'd6:    ealu = 3'b011;
          default: ealu = 3'b010;
        endcase
      end
      7'h03, 7'h23: legal = (if3 == 3'd2);
      7'h63: begin legal = (if3 == 3'd0); ealu = 3'b001; end
      7'h6F, 7'h37: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    is_mem = (iop == 7'h03) || (iop == 7'h23);
    lw = (iop == 7'h03);

    for (int k = 0; k <= fw; k++) begin
      imem_ready = (k == fw); dmem_ready = 1'($urandom); op = 7'($urandom);
      @(negedge clk);
      e = '0; e.ir_en = imem_ready;
      chk_ctl("fetch", e, '1);
      @(posedge clk); #1;
    end
    op = iop; f3 = if3; f7 = if7; zero = iz;
    imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
    @(negedge clk);
    chk_ctl("decode", '0, '1);
    @(posedge clk); #1;
    imem_ready = 1'($urandom); dmem_ready = 1'($urandom);

    if (!legal) begin
      @(negedge clk);
      e = '0; e.pc_en = 1'b1; e.jump = 2'b11; e.trap = 1'b1;
      chk_ctl("trap", e, '1);
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
      e = '0; m = '0;
      m.pc_en = 1'b1; m.req = 1'b1; m.trap = 1'b1; m.ir_en = 1'b1;
      case (iop)
        7'h33, 7'h13: begin
          m.alu = '1; m.asrc = 1'b1; m.rw = 1'b1;
          e.alu = ealu; e.asrc = (iop == 7'h13);
        end
        7'h03, 7'h23: begin
          m.alu = '1; m.asrc = 1'b1; m.imm = '1;
          e.asrc = 1'b1; e.imm = lw ? 2'b00 : 2'b01;
        end
        7'h63: begin
          m.alu = '1; m.imm = '1; m.br = 1'b1; m.jump = '1;
          e.alu = 3'b001; e.imm = 2'b10; e.br = iz; e.jump = 2'b01; e.pc_en = 1'b1;
        end
        7'h6F: begin
          m.imm = '1; m.res = '1; m.rw = 1'b1; m.jump = '1;
          e.imm = 2'b11; e.res = 2'b11; e.rw = 1'b1; e.jump = 2'b10; e.pc_en = 1'b1;
        end
        default: begin
          m.res = '1; e.res = 2'b10;
        end
      endcase
      chk_ctl("exec", e, m);
      if (iop == 7'h63 || iop == 7'h6F) m_instret++;
      @(posedge clk); #1;

      if (is_mem) begin
        n = to ? (1 << TW) : mw + 1;
        for (int k = 0; k < n; k++) begin
          dmem_ready = !to && (k == mw); imem_ready = 1'($urandom);
          if (k == rst_at) begin
            @(negedge clk); #1;
            rst_n = 1'b0;
            #1;
            chk_ctl("rst_mid_mem", '0, '1);
            chk("rst_instret", instret, 32'd0);
            m_instret = '0;
            release_reset();
            return;
          end
          @(negedge clk);
          e = '0; m = '0;
          m.pc_en = 1'b1; m.req = 1'b1; m.we = 1'b1; m.rw = 1'b1; m.asrc = 1'b1;
          m.alu = '1; m.imm = '1; m.trap = 1'b1; m.ir_en = 1'b1;
          e.req = 1'b1; e.we = !lw; e.asrc = 1'b1; e.imm = lw ? 2'b00 : 2'b01;
          if (dmem_ready) begin
            e.pc_en = 1'b1; e.jump = 2'b01; m.jump = '1; e.rw = lw;
            if (lw) begin e.res = 2'b01; m.res = '1; end
          end
          chk_ctl("mem", e, m);
          if (dmem_ready) m_instret++;
          @(posedge clk); #1;
        end
        if (to) begin
          dmem_ready = 1'b0;
          @(negedge clk);
          e = '0; e.pc_en = 1'b1; e.jump = 2'b11; e.trap = 1'b1;
          chk_ctl("timeout_trap", e, '1);
          @(posedge clk); #1;
        end
      end else if (iop != 7'h63 && iop != 7'h6F) begin
        @(negedge clk);
        e = '0; m = '0;
        m.pc_en = 1'b1; m.req = 1'b1; m.rw = 1'b1; m.jump = '1; m.res = '1;
        m.trap = 1'b1; m.ir_en = 1'b1;
        e.pc_en = 1'b1; e.rw = 1'b1; e.jump = 2'b01; e.res = (iop == 7'h37) ? 2'b10 : 2'b00;
        chk_ctl("wb", e, m);
        m_instret++;
        @(posedge clk); #1;
      end
    end
    chk("instret", instret, m_instret);
  endtask

  initial begin
    logic [6:0] ops [9];
    logic [6:0] rop;
    logic [2:0] rf3;
    int idx;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h7F, 7'h00};

    @(negedge clk);
    chk_ctl("reset_hold", '0, '1);
    chk("reset_hold_instret", instret, 32'd0);
    imem_ready = 1'b1;
    release_reset();

    run_instr(7'h33, 3'd0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_instr(7'h33, 3'd0, 1'b1, 1'b0, 1, 0, -1, 1'b0);
    run_instr(7'h63, 3'd0, 1'b0, 1'b1, 0, 0, -1, 1'b0);
    run_instr(7'h63, 3'd0, 1'b0, 1'b0, 2, 0, -1, 1'b0);
    run_instr(7'h03, 3'd2, 1'b0, 1'b0, 0, 5, -1, 1'b0);
    run_instr(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_instr(7'h37, 3'd5, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_instr(7'h6F, 3'd1, 1'b1, 1'b0, 0, 0, -1, 1'b0);
    run_instr(7'h23, 3'd2, 1'b0, 1'b0, 1, 3, -1, 1'b0);
    run_instr(7'h13, 3'd3, 1'b0, 1'b0, 0, 0, -1, 1'b0);

    for (int i = 0; i < 80; i++) begin
      idx = $urandom_range(0, 8);
      rop = (idx == 8) ? 7'($urandom) : ops[idx];
      rf3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (rop == 7'h03 || rop == 7'h23) rf3 = 3'd2;
        if (rop == 7'h63) rf3 = 3'd0;
      end
      run_instr(rop, rf3, 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 4), -1, 1'b0);
    end

    run_instr(7'h03, 3'd2, 1'b0, 1'b0, 0, 5, 2, 1'b0);
    run_instr(7'h13, 3'd7, 1'b0, 1'b0, 0, 0, -1, 1'b0);

`ifdef CTRL_FSM_TIMEOUT_EN
    run_instr(7'h23, 3'd2, 1'b0, 1'b0, 0, 0, -1, 1'b1);
    run_instr(7'h03, 3'd2, 1'b0, 1'b0, 0, 7, -1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
